dbg_cmd_decoder: RTL and testbench
==================================

Name: dbg_cmd_decoder

Overview:
- Consumes 32-bit words from the UART word receiver and assembles them into debugger command frames.
- A frame is an opcode word, optionally followed by an address word and a data word.
- Issues one transaction per frame to the MCU debug port, then returns exactly one 32-bit reply word to the UART word transmitter.
- Sits between the UART word receiver and the MCU debug interface.

Parameters:
- CLK_RATE, 50, rate of clk in MHz.
- IW_TIMEOUT, 200, maximum gap between words of one frame, in ms; TIMEOUT_CLKS = CLK_RATE*IW_TIMEOUT*1000.
- ACK_TIMEOUT_CLKS, 1024, maximum clk cycles from mcu_req asserted to mcu_ack.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- rx_ready  in  1  one-shot: rx_word valid this cycle.
- rx_word  in  32  received word, big-endian assembled.
- tx_start  out  1  one-shot: send tx_word.
- tx_word  out  32  reply word; held stable until the next tx_start.
- tx_busy  in  1  transmitter busy; tx_start is only allowed when low.
- mcu_req  out  1  transaction request; level, held until mcu_ack.
- mcu_op  out  3  opcode (package enum).
- mcu_addr  out  32  address.
- mcu_wdata  out  32  write data.
- mcu_ack  in  1  one-cycle acknowledge.
- mcu_rdata  in  32  read data, valid with mcu_ack.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (async, rst high): state IDLE; tx_start=0; tx_word=0; mcu_req=0; mcu_op=0; mcu_addr=0; mcu_wdata=0; busy=0; both counters cleared.
- Opcode is rx_word[7:0]; bits [31:8] are ignored.
- Opcode table:
  - PING 0x00: no args, no MCU transaction, reply 0x0000_0001.
  - PAUSE 0x01: no args.
  - RESUME 0x02: no args.
  - STATUS 0x03: no args, reply = mcu_rdata.
  - MEM_RD 0x04: one arg (addr), reply = mcu_rdata.
  - MEM_WR 0x05: two args (addr, data).
  - REG_RD 0x06: one arg (addr), reply = mcu_rdata.
  - REG_WR 0x07: two args (addr, data).
  - All other opcodes: reply ERR_OPCODE 0xFFFF_FFFF with no MCU transaction.
- Reply for PAUSE, RESUME, MEM_WR and REG_WR is 0x0000_0000.
- States:
  - IDLE: on rx_ready, latch the opcode.
    - 0 args: ->ISSUE (PING and invalid opcodes go straight ->REPLY).
    - Otherwise ->GET_ADDR.
  - GET_ADDR: on rx_ready, latch mcu_addr; ->GET_DATA for writes, else ->ISSUE.
  - GET_DATA: on rx_ready, latch mcu_wdata; ->ISSUE.
  - ISSUE: assert mcu_req with mcu_op, mcu_addr and mcu_wdata stable; ->WAIT_ACK.
  - WAIT_ACK: mcu_req stays high.
    - On mcu_ack: deassert mcu_req the same edge, capture reply, ->REPLY.
    - If the counter reaches ACK_TIMEOUT_CLKS first: drop mcu_req, reply ERR_ACK 0xFFFF_FFFE, ->REPLY.
  - REPLY: when tx_busy=0, pulse tx_start for exactly one cycle with tx_word valid; ->IDLE. Waits indefinitely while tx_busy=1.
- Latency: PING with rx_ready at edge N gives tx_start high in cycle N+1 when tx_busy=0. mcu_req rises one cycle after the final argument word is latched.
- Inter-word timeout: in GET_ADDR/GET_DATA the counter clears on each rx_ready. At TIMEOUT_CLKS the partial frame is discarded silently (no reply) and the state returns to IDLE.
- rx_ready in ISSUE, WAIT_ACK or REPLY: the word is dropped; no queueing.
- mcu_ack outside WAIT_ACK is ignored.
- mcu_ack in the same cycle the ack counter hits its limit: the ack wins.
- Reset mid-transaction: mcu_req drops immediately (async); no reply is sent.
- Counter widths: $clog2(limit+1); the counters never wrap.

Decomposition:
- Package dbg_pkg holds:
  - typedef enum logic [7:0] of opcodes;
  - typedef enum logic [2:0] mcu_op_t;
  - ERR_OPCODE, ERR_ACK and PING_REPLY constants;
  - a function returning the argument count per opcode.
- No sub-module is needed; the timeout counter stays inline.

Test Plan:
- PING word 0x0000_0000, tx_busy=0 -> tx_start one cycle later, tx_word=0x0000_0001, mcu_req never asserted.
- MEM_RD 0x04, addr 0x0000_1000; MCU acks after 5 cycles with rdata 0xDEAD_BEEF -> mcu_op=MEM_RD and mcu_addr=0x1000 held for 5 cycles; then tx_word=0xDEAD_BEEF, tx_start once.
- MEM_WR 0x05, 0x0000_2000, 0x1234_5678 -> mcu_addr/mcu_wdata match; reply 0x0000_0000.
- Opcode 0xAB -> reply 0xFFFF_FFFF, no mcu_req. Separately, REG_RD with mcu_ack never asserted -> mcu_req drops after 1024 cycles, reply 0xFFFF_FFFE.
- MEM_WR 0x05 then only the address word; wait TIMEOUT_CLKS (small CLK_RATE/IW_TIMEOUT in sim) -> no tx_start, busy=0; a following PING is answered normally.
- tx_busy=1 during REPLY for 100 cycles -> tx_start withheld, then a single pulse. Separately, rst asserted during WAIT_ACK -> mcu_req=0 immediately, busy=0, no reply.

Source files
------------

// File: rtl/dbg_cmd_decoder_pkg.sv
// Shared opcode/MCU-op encodings, reply constants and frame-shape helpers
// for the debugger command decoder.
package dbg_pkg;

    typedef enum logic [7:0] {
        OP_PING   = 8'h00,
        OP_PAUSE  = 8'h01,
        OP_RESUME = 8'h02,
        OP_STATUS = 8'h03,
        OP_MEM_RD = 8'h04,
        OP_MEM_WR = 8'h05,
        OP_REG_RD = 8'h06,
        OP_REG_WR = 8'h07
    } opcode_t;

    typedef enum logic [2:0] {
        MCU_NOP    = 3'd0,
        MCU_PAUSE  = 3'd1,
        MCU_RESUME = 3'd2,
        MCU_STATUS = 3'd3,
        MCU_MEM_RD = 3'd4,
        MCU_MEM_WR = 3'd5,
        MCU_REG_RD = 3'd6,
        MCU_REG_WR = 3'd7
    } mcu_op_t;

    localparam logic [31:0] ERR_OPCODE = 32'hFFFF_FFFF;
    localparam logic [31:0] ERR_ACK    = 32'hFFFF_FFFE;
    localparam logic [31:0] PING_REPLY = 32'h0000_0001;

    function automatic logic [1:0] arg_count(input logic [7:0] op);
        case (op)
            OP_MEM_RD, OP_REG_RD: return 2'd1;
            OP_MEM_WR, OP_REG_WR: return 2'd2;
            default:              return 2'd0;
        endcase
    endfunction

    // Opcodes that turn into a transaction on the MCU debug port
    function automatic logic is_mcu_op(input logic [7:0] op);
        return (op != OP_PING) && (op <= OP_REG_WR);
    endfunction

    function automatic logic returns_rdata(input logic [7:0] op);
        return (op == OP_STATUS) || (op == OP_MEM_RD) || (op == OP_REG_RD);
    endfunction

endpackage

// File: rtl/dbg_cmd_decoder_if.sv
// UART word and MCU debug-port signals of the command decoder; master is the
// decoder side, slave is the surrounding UART/MCU side.
interface dbg_cmd_decoder_if;
    import dbg_pkg::*;

    logic        rx_ready;
    logic [31:0] rx_word;
    logic        tx_start;
    logic [31:0] tx_word;
    logic        tx_busy;
    logic        mcu_req;
    mcu_op_t     mcu_op;
    logic [31:0] mcu_addr;
    logic [31:0] mcu_wdata;
    logic        mcu_ack;
    logic [31:0] mcu_rdata;
    logic        busy;

    modport master (
        input  rx_ready, rx_word, tx_busy, mcu_ack, mcu_rdata,
        output tx_start, tx_word, mcu_req, mcu_op, mcu_addr, mcu_wdata, busy
    );

    modport slave (
        output rx_ready, rx_word, tx_busy, mcu_ack, mcu_rdata,
        input  tx_start, tx_word, mcu_req, mcu_op, mcu_addr, mcu_wdata, busy
    );

endinterface

// File: rtl/dbg_cmd_decoder.sv
// Assembles UART words into debugger command frames, issues one MCU debug
// transaction per frame and returns exactly one reply word.
module dbg_cmd_decoder
    import dbg_pkg::*;
#(
    parameter int CLK_RATE         = 50,
    parameter int IW_TIMEOUT       = 200,
    parameter int ACK_TIMEOUT_CLKS = 1024
) (
    input logic              clk,
    input logic              rst,
    dbg_cmd_decoder_if.master bus
);

    localparam int TIMEOUT_CLKS = CLK_RATE * IW_TIMEOUT * 1000;
    localparam int IW_W         = $clog2(TIMEOUT_CLKS + 1);
    localparam int ACK_W        = $clog2(ACK_TIMEOUT_CLKS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GET_ADDR,
        S_GET_DATA,
        S_ISSUE,
        S_WAIT_ACK,
        S_REPLY
    } state_t;

    state_t      state, state_n;
    logic [7:0]  op_q;
    logic [31:0] reply_q;
    logic [IW_W-1:0]  iw_cnt;
    logic [ACK_W-1:0] ack_cnt;
    logic        iw_expired, ack_expired;

    // Both limits fire on the last counted cycle so the counters never wrap
    assign iw_expired  = (iw_cnt  == IW_W'(TIMEOUT_CLKS - 1));
    assign ack_expired = (ack_cnt == ACK_W'(ACK_TIMEOUT_CLKS - 1));
    assign bus.busy    = (state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: begin
                if (bus.rx_ready) begin
                    if (!is_mcu_op(bus.rx_word[7:0]))
                        state_n = S_REPLY;
                    else if (arg_count(bus.rx_word[7:0]) == 2'd0)
                        state_n = S_ISSUE;
                    else
                        state_n = S_GET_ADDR;
                end
            end
            S_GET_ADDR: begin
                if (bus.rx_ready)
                    state_n = (arg_count(op_q) == 2'd2) ? S_GET_DATA : S_ISSUE;
                else if (iw_expired)
                    state_n = S_IDLE;
            end
            S_GET_DATA: begin
                if (bus.rx_ready)  state_n = S_ISSUE;
                else if (iw_expired) state_n = S_IDLE;
            end
            S_ISSUE:    state_n = S_WAIT_ACK;
            S_WAIT_ACK: if (bus.mcu_ack || ack_expired) state_n = S_REPLY;
            S_REPLY:    if (!bus.tx_busy) state_n = S_IDLE;
            default:    state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q          <= 8'h00;
            reply_q       <= 32'h0;
            iw_cnt        <= '0;
            ack_cnt       <= '0;
            bus.tx_start  <= 1'b0;
            bus.tx_word   <= 32'h0;
            bus.mcu_req   <= 1'b0;
            bus.mcu_op    <= MCU_NOP;
            bus.mcu_addr  <= 32'h0;
            bus.mcu_wdata <= 32'h0;
        end else begin
            bus.tx_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.rx_ready) begin
                        op_q    <= bus.rx_word[7:0];
                        reply_q <= (bus.rx_word[7:0] == OP_PING) ? PING_REPLY : ERR_OPCODE;
                    end
                end
                S_GET_ADDR: begin
                    if (bus.rx_ready) bus.mcu_addr <= bus.rx_word;
                    iw_cnt <= (bus.rx_ready || iw_expired) ? '0 : iw_cnt + 1'b1;
                end
                S_GET_DATA: begin
                    if (bus.rx_ready) bus.mcu_wdata <= bus.rx_word;
                    iw_cnt <= (bus.rx_ready || iw_expired) ? '0 : iw_cnt + 1'b1;
                end
                S_ISSUE: begin
                    bus.mcu_req <= 1'b1;
                    bus.mcu_op  <= mcu_op_t'(op_q[2:0]);
                end
                S_WAIT_ACK: begin
                    // An ack landing on the limit cycle still counts as a response
                    if (bus.mcu_ack) begin
                        bus.mcu_req <= 1'b0;
                        reply_q     <= returns_rdata(op_q) ? bus.mcu_rdata : 32'h0;
                        ack_cnt     <= '0;
                    end else if (ack_expired) begin
                        bus.mcu_req <= 1'b0;
                        reply_q     <= ERR_ACK;
                        ack_cnt     <= '0;
                    end else begin
                        ack_cnt <= ack_cnt + 1'b1;
                    end
                end
                S_REPLY: begin
                    if (!bus.tx_busy) begin
                        bus.tx_start <= 1'b1;
                        bus.tx_word  <= reply_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dbg_cmd_decoder.sv
// Randomised frame-level bench for dbg_cmd_decoder against an opcode-table model.
module tb_dbg_cmd_decoder;
    import dbg_pkg::*;

    localparam int ACK_LIM = 1024;
    localparam int IW_LIM  = 1 * 1 * 1000;

    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   tx_cnt = 0;
    int   req_rise = 0;
    logic req_d = 1'b0;

    dbg_cmd_decoder_if dif();

    dbg_cmd_decoder #(
        .CLK_RATE(1),
        .IW_TIMEOUT(1),
        .ACK_TIMEOUT_CLKS(ACK_LIM)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(dif)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (dif.tx_start === 1'b1) tx_cnt <= tx_cnt + 1;
        if (dif.mcu_req === 1'b1 && req_d !== 1'b1) req_rise <= req_rise + 1;
        req_d <= dif.mcu_req;
    end

    // Reference model: opcode table from the command set
    function automatic int m_nargs(input logic [7:0] op);
        case (op)
            8'h04, 8'h06: return 1;
            8'h05, 8'h07: return 2;
            default:      return 0;
        endcase
    endfunction

    function automatic bit m_mcu(input logic [7:0] op);
        return (op >= 8'h01) && (op <= 8'h07);
    endfunction

    function automatic logic [31:0] m_reply(input logic [7:0] op, input logic [31:0] rdata,
                                            input bit timed_out);
        if (op == 8'h00) return 32'h0000_0001;
        if (op > 8'h07)  return 32'hFFFF_FFFF;
        if (timed_out)   return 32'hFFFF_FFFE;
        if (op == 8'h03 || op == 8'h04 || op == 8'h06) return rdata;
        return 32'h0000_0000;
    endfunction

    task automatic send_word(input logic [31:0] w);
        logic [31:0] r;
        dif.rx_ready = 1'b1;
        dif.rx_word  = w;
        @(negedge clk);
        r = $urandom;
        dif.rx_ready = 1'b0;
        dif.rx_word  = r;
    endtask

    // ack_dly = 0 means the MCU never acknowledges
    task automatic run_frame(input string tag, input logic [7:0] op, input logic [31:0] addr,
                             input logic [31:0] data, input logic [31:0] rdata,
                             input int ack_dly, input int busy_hold, input int gap);
        int n, tx0, rr0, hi;
        bit mcu, stable, quiet;
        logic [31:0] exp_w, tmp;
        n   = m_nargs(op);
        mcu = m_mcu(op);
        tx0 = tx_cnt;
        rr0 = req_rise;
        dif.tx_busy = (busy_hold > 0);
        tmp = $urandom;
        send_word({tmp[31:8], op});
        if (n >= 1) begin repeat (gap) @(negedge clk); send_word(addr); end
        if (n == 2) begin repeat (gap) @(negedge clk); send_word(data); end
        exp_w = m_reply(op, rdata, 1'b0);
        if (mcu) begin
            n_chk++;
            if (dif.mcu_req !== 1'b0) $display("FAIL %s req_early: got %b want 0", tag, dif.mcu_req);
            else n_pass++;
            @(negedge clk);
            n_chk++;
            if (dif.mcu_req !== 1'b1) $display("FAIL %s req_rise: got %b want 1", tag, dif.mcu_req);
            else n_pass++;
            n_chk++;
            if (dif.mcu_op !== op[2:0]) $display("FAIL %s mcu_op: got %h want %h", tag, dif.mcu_op, op[2:0]);
            else n_pass++;
            if (n >= 1) begin
                n_chk++;
                if (dif.mcu_addr !== addr) $display("FAIL %s mcu_addr: got %h want %h", tag, dif.mcu_addr, addr);
                else n_pass++;
            end
            if (n == 2) begin
                n_chk++;
                if (dif.mcu_wdata !== data) $display("FAIL %s mcu_wdata: got %h want %h", tag, dif.mcu_wdata, data);
                else n_pass++;
            end
            hi = 1;
            if (ack_dly > 0) begin
                stable = 1'b1;
                while (hi < ack_dly) begin
                    @(negedge clk);
                    if (dif.mcu_req !== 1'b1 || dif.mcu_op !== op[2:0] ||
                        (n >= 1 && dif.mcu_addr !== addr)) stable = 1'b0;
                    hi++;
                end
                dif.mcu_ack   = 1'b1;
                dif.mcu_rdata = rdata;
                @(negedge clk);
                dif.mcu_ack   = 1'b0;
                dif.mcu_rdata = $urandom;
                n_chk++;
                if (stable !== 1'b1) $display("FAIL %s req_hold: got unstable want stable for %0d cycles", tag, ack_dly);
                else n_pass++;
            end else begin
                for (int i = 0; i < ACK_LIM + 50; i++) begin
                    @(negedge clk);
                    if (dif.mcu_req !== 1'b1) break;
                    hi++;
                end
                n_chk++;
                if (hi != ACK_LIM) $display("FAIL %s ack_timeout_len: got %0d want %0d", tag, hi, ACK_LIM);
                else n_pass++;
                exp_w = m_reply(op, rdata, 1'b1);
            end
            n_chk++;
            if (dif.mcu_req !== 1'b0) $display("FAIL %s req_drop: got %b want 0", tag, dif.mcu_req);
            else n_pass++;
        end
        if (busy_hold > 0) begin
            quiet = 1'b1;
            repeat (busy_hold) begin
                if (dif.tx_start !== 1'b0 || dif.busy !== 1'b1) quiet = 1'b0;
                @(negedge clk);
            end
            n_chk++;
            if (quiet !== 1'b1) $display("FAIL %s tx_withheld: got pulse/idle want held for %0d", tag, busy_hold);
            else n_pass++;
            dif.tx_busy = 1'b0;
        end
        n_chk++;
        if (dif.tx_start !== 1'b0) $display("FAIL %s tx_early: got %b want 0", tag, dif.tx_start);
        else n_pass++;
        @(negedge clk);
        n_chk++;
        if (dif.tx_start !== 1'b1) $display("FAIL %s tx_start: got %b want 1", tag, dif.tx_start);
        else n_pass++;
        n_chk++;
        if (dif.tx_word !== exp_w) $display("FAIL %s tx_word: got %h want %h", tag, dif.tx_word, exp_w);
        else n_pass++;
        n_chk++;
        if (dif.busy !== 1'b0) $display("FAIL %s busy_after: got %b want 0", tag, dif.busy);
        else n_pass++;
        @(negedge clk);
        n_chk++;
        if (tx_cnt - tx0 != 1) $display("FAIL %s tx_count: got %0d want 1", tag, tx_cnt - tx0);
        else n_pass++;
        n_chk++;
        if (req_rise - rr0 != (mcu ? 1 : 0)) $display("FAIL %s req_count: got %0d want %0d", tag, req_rise - rr0, mcu ? 1 : 0);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        n_chk++;
        if ({dif.tx_start, dif.tx_word, dif.mcu_req, dif.mcu_op, dif.mcu_addr, dif.mcu_wdata, dif.busy} !== 100'h0)
            $display("FAIL reset_outputs: got %b/%h/%b/%h/%h/%h/%b want all 0", dif.tx_start, dif.tx_word,
                     dif.mcu_req, dif.mcu_op, dif.mcu_addr, dif.mcu_wdata, dif.busy);
        else n_pass++;
        rst = 1'b0;
        @(negedge clk);
        n_chk++;
        if (dif.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", dif.busy);
        else n_pass++;
    endtask

    task automatic test_directed();
        run_frame("ping",   8'h00, 32'h0, 32'h0, 32'h0, 0, 0, 0);
        run_frame("mem_rd", 8'h04, 32'h0000_1000, 32'h0, 32'hDEAD_BEEF, 5, 0, 0);
        run_frame("mem_wr", 8'h05, 32'h0000_2000, 32'h1234_5678, 32'hCAFE_F00D, 3, 0, 1);
        run_frame("bad_op", 8'hAB, 32'h0, 32'h0, 32'h0, 0, 0, 0);
        run_frame("status", 8'h03, 32'h0, 32'h0, 32'h5A5A_0F0F, 1, 0, 0);
    endtask

    task automatic test_ack_timeout();
        run_frame("ack_to",    8'h06, 32'h0000_0040, 32'h0, 32'h1111_2222, 0, 0, 0);
        run_frame("ack_limit", 8'h06, 32'h0000_0044, 32'h0, 32'h3333_4444, ACK_LIM, 0, 0);
    endtask

    task automatic test_iw_timeout();
        int tx0, rr0;
        tx0 = tx_cnt;
        rr0 = req_rise;
        send_word(32'h0000_0005);
        send_word(32'h0000_2000);
        repeat (IW_LIM - 1) @(negedge clk);
        n_chk++;
        if (dif.busy !== 1'b1) $display("FAIL iw_before_limit: got busy=%b want 1", dif.busy);
        else n_pass++;
        @(negedge clk);
        n_chk++;
        if (dif.busy !== 1'b0) $display("FAIL iw_at_limit: got busy=%b want 0", dif.busy);
        else n_pass++;
        repeat (3) @(negedge clk);
        n_chk++;
        if (tx_cnt != tx0 || req_rise != rr0)
            $display("FAIL iw_silent: got tx=%0d req=%0d want 0 0", tx_cnt - tx0, req_rise - rr0);
        else n_pass++;
        run_frame("iw_ping", 8'h00, 32'h0, 32'h0, 32'h0, 0, 0, 0);
    endtask

    task automatic test_tx_busy();
        run_frame("busy_ping",  8'h00, 32'h0, 32'h0, 32'h0, 0, 100, 0);
        run_frame("busy_regwr", 8'h07, 32'h0000_0080, 32'hA5A5_5A5A, 32'hFFFF_0000, 2, 100, 0);
    endtask

    task automatic test_dropped_and_stray();
        int tx0;
        tx0 = tx_cnt;
        send_word(32'h0000_0004);
        send_word(32'h0000_0300);
        @(negedge clk);
        send_word(32'h0000_0000);
        dif.mcu_ack   = 1'b1;
        dif.mcu_rdata = 32'h0BAD_F00D;
        @(negedge clk);
        dif.mcu_ack   = 1'b0;
        @(negedge clk);
        n_chk++;
        if (dif.tx_start !== 1'b1 || dif.tx_word !== 32'h0BAD_F00D)
            $display("FAIL drop_reply: got %b/%h want 1/0badf00d", dif.tx_start, dif.tx_word);
        else n_pass++;
        dif.mcu_ack = 1'b1;
        @(negedge clk);
        dif.mcu_ack = 1'b0;
        repeat (5) @(negedge clk);
        n_chk++;
        if (tx_cnt - tx0 != 1 || dif.busy !== 1'b0 || dif.mcu_req !== 1'b0)
            $display("FAIL drop_stray: got tx=%0d busy=%b req=%b want 1 0 0", tx_cnt - tx0, dif.busy, dif.mcu_req);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int tx0;
        tx0 = tx_cnt;
        send_word(32'h0000_0003);
        @(negedge clk);
        n_chk++;
        if (dif.mcu_req !== 1'b1) $display("FAIL rst_mid_req_up: got %b want 1", dif.mcu_req);
        else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_chk++;
        if (dif.mcu_req !== 1'b0 || dif.busy !== 1'b0)
            $display("FAIL rst_mid_async: got req=%b busy=%b want 0 0", dif.mcu_req, dif.busy);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        n_chk++;
        if (tx_cnt != tx0 || dif.mcu_req !== 1'b0)
            $display("FAIL rst_mid_noreply: got tx=%0d req=%b want 0 0", tx_cnt - tx0, dif.mcu_req);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [7:0]  op;
        logic [31:0] a, d, r;
        int sel;
        for (int k = 0; k < 25; k++) begin
            sel = $urandom_range(0, 9);
            op  = (sel < 8) ? 8'(sel) : 8'($urandom_range(8, 255));
            a   = $urandom;
            d   = $urandom;
            r   = $urandom;
            run_frame("random", op, a, d, r, $urandom_range(1, 8), 0, $urandom_range(0, 2));
        end
    endtask

    initial begin
        dif.rx_ready  = 1'b0;
        dif.rx_word   = 32'h0;
        dif.tx_busy   = 1'b0;
        dif.mcu_ack   = 1'b0;
        dif.mcu_rdata = 32'h0;
        test_reset();
        test_directed();
        test_ack_timeout();
        test_iw_timeout();
        test_tx_busy();
        test_dropped_and_stray();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
